// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and defaults for the parametrised synchronous FIFO
//
// Purpose: output-mode enum and default geometry used by sync_fifo_param.
// Ports:   none (package).
package fifo_pkg;

    // FIFO_STD: registered read data; FIFO_FWFT: head of queue visible without a read.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int FIFO_DEF_DATA_W = 8;
    localparam int FIFO_DEF_DEPTH  = 16;

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - two-port FIFO storage, synchronous write, asynchronous read
//
// Purpose: DEPTH x DATA_W register array backing the FIFO. Contents are not reset.
// Ports:
//   clk_i      clock, write on rising edge
//   wr_en_i    write strobe
//   waddr_i    write address
//   wdata_i    write data
//   raddr_i    read address (combinational read)
//   rdata_o    read data
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, almost flags and error pulses
//
// Purpose: DEPTH-entry FIFO using every slot, simultaneous read/write, standard or
//          first-word-fall-through output.
// Ports:
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   wr_en, din    write request and data (ignored when full)
//   rd_en         read request (ignored when empty)
//   dout          read data (registered in FIFO_STD, head of queue in FIFO_FWFT)
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      one-cycle pulse after a write attempted while full
//   underflow     one-cycle pulse after a read attempted while empty
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int         DATA_W   = FIFO_DEF_DATA_W,
    parameter int         DEPTH    = FIFO_DEF_DEPTH,
    parameter int         AF_LEVEL = DEPTH - 2,
    parameter int         AE_LEVEL = 2,
    parameter fifo_mode_e MODE     = FIFO_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      din,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two and >= 2");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
        $fatal(1, "sync_fifo_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_ok;
    logic              rd_ok;

    // Flags come straight from the registered count, so acceptance uses pre-edge state.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // No bypass: a write into an empty FIFO is not readable in the same cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .wr_en_i (wr_ok),
        .waddr_i (wptr_q),
        .wdata_i (din),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;

        // Pointers are exactly AW bits wide, so DEPTH-1 + 1 wraps to 0 on its own.
        if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = mem_rdata;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // FWFT shows the head directly and forces zero when there is nothing to show.
    assign dout = (MODE == FIFO_FWFT) ? (empty ? '0 : mem_rdata) : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param in both output modes
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int CW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_count, f_count;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .MODE(FIFO_STD)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    // Reference model: contents as a plain queue, plus expected error pulses.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;
    logic          mon_en  = 1'b0;
    logic [DW-1:0] std_hold = '0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, push expected read data.
    task automatic cycle(input logic r_st, input logic w, input logic [DW-1:0] d, input logic r);
        bit was_full;
        bit was_empty;
        rst   = r_st;
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        if (r_st) begin
            mq.delete();
            exp_q.push_back('0);
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            was_full  = (mq.size() == DP);
            was_empty = (mq.size() == 0);
            exp_ovf   = w && was_full;
            exp_unf   = r && was_empty;
            if (r && !was_empty) exp_q.push_back(mq.pop_front());
            if (w && !was_full)  mq.push_back(d);
        end
        mon_en = 1'b1;
        #1;
    endtask

    // Monitor: checks every observable output half a cycle after each edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int n;
            n = mq.size();
            if (exp_q.size() > 0) std_hold = exp_q.pop_front();
            chk("count",        32'(s_count), 32'(n));
            chk("fwft_count",   32'(f_count), 32'(n));
            chk("empty",        32'(s_empty), 32'(n == 0));
            chk("full",         32'(s_full),  32'(n == DP));
            chk("almost_full",  32'(s_af),    32'(n >= DP - 2));
            chk("almost_empty", 32'(s_ae),    32'(n <= 2));
            chk("fwft_empty",   32'(f_empty), 32'(n == 0));
            chk("fwft_full",    32'(f_full),  32'(n == DP));
            chk("fwft_af",      32'(f_af),    32'(n >= DP - 2));
            chk("fwft_ae",      32'(f_ae),    32'(n <= 2));
            chk("overflow",     32'(s_ovf),   32'(exp_ovf));
            chk("underflow",    32'(s_unf),   32'(exp_unf));
            chk("fwft_overflow",  32'(f_ovf), 32'(exp_ovf));
            chk("fwft_underflow", 32'(f_unf), 32'(exp_unf));
            chk("std_dout",     32'(s_dout),  32'(std_hold));
            chk("fwft_dout",    32'(f_dout),  (n == 0) ? 32'd0 : 32'(mq[0]));
        end
    end

    initial begin
        // Reset and idle.
        cycle(1'b1, 1'b1, 8'hFF, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Drain in order, then one rejected read; dout holds the last word.
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Simultaneous write/read at count 8 across pointer wrap.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous request while full reads only; while empty writes only.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'h77, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Single word into empty FIFO, visible without a read in FWFT, then popped.
        cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset with count 5 and a concurrent write, then a rejected read.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'h99, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomised traffic with shifting write/read bias to visit full and empty.
        for (int i = 0; i < 3000; i++) begin
            int wb;
            int rb;
            wb = ((i / 200) % 2 == 0) ? 70 : 30;
            rb = 100 - wb;
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 99) < wb),
                  8'($urandom),
                  ($urandom_range(0, 99) < rb));
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous single-clock FIFO; next-generation replacement for the fixed 8x16 FIFO in the test environment. It uses the full configurable depth with no wasted slot, supports simultaneous read and write, and adds occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. Mode selects standard (registered-read) or first-word-fall-through (FWFT) output.

## Interface
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, entry count; power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- MODE, FIFO_STD, fifo_mode_e: FIFO_STD or FIFO_FWFT
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- dout  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected because full
- underflow  out  1  one-cycle pulse: read rejected because empty

## Operation
- Write is accepted iff wr_en && !full. Read is accepted iff rd_en && !empty. Both conditions use the flag values before the edge.
- Both accepted in the same cycle: both take effect and count is unchanged.
- When full, wr_en && rd_en results in a read only. When empty, wr_en && rd_en results in a write only. No bypass path.
- wptr/rptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. There is no special-case wrap logic.
- count increments on a write-only cycle, decrements on a read-only cycle, and is otherwise held. It never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
- FIFO_STD: dout is a register, loaded with mem[rptr] on an accepted read and held otherwise.
- FIFO_FWFT: dout = mem[rptr] when !empty, and 0 when empty. An accepted read pops the current head.
- overflow is registered, high for exactly one cycle after an edge where wr_en && full. underflow is the same, for rd_en && empty.
- Reset clears wptr, rptr, count, dout, overflow and underflow. Memory contents are not cleared.
- Reset values: empty=1, almost_empty=1, full=0, almost_full=0, count=0, dout=0, overflow=0, underflow=0.
- Reset mid-operation discards all stored data. Any wr_en/rd_en in the reset cycle is ignored.
- Elaboration-time checks: DEPTH is a power of two and >=2, and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. A violation is a fatal error.

## Timing
- Write accepted at edge t: count, empty, full and the almost flags reflect it after t.
- FWFT write into empty FIFO at edge t: dout is valid and empty=0 after t (1-cycle latency).
- STD read accepted at edge t: new dout is valid after t. Before t, dout holds the previously read word.
- overflow/underflow are asserted in the cycle after the offending edge and deassert after one cycle unless the condition repeats.
- Throughput: one write and one read per cycle sustained.

## Structure
- fifo_pkg holds the fifo_mode_e enum (FIFO_STD, FIFO_FWFT) and the default constants FIFO_DEF_DATA_W=8 and FIFO_DEF_DEPTH=16.
- Sub-module fifo_mem_2p(DATA_W, DEPTH) provides the storage: one synchronous write port and one asynchronous read port (address rptr).
- Pointer, count, flag, error and dout logic live in sync_fifo_param.

## Test plan
- Reset then idle: empty=1, almost_empty=1, count=0, dout=0, no error pulses.
- Fill with 16 writes of 0x00..0x0F (DEPTH=16): count reaches 16, full=1, almost_full from count=14. A 17th write gives overflow=1 for one cycle and count stays 16.
- Drain after fill (STD): 16 reads return 0x00..0x0F in order, each one cycle after its read edge. Then empty=1, and one extra read gives underflow=1 and dout holds 0x0F.
- Wrap and simultaneous access: hold count=8, then 40 cycles of wr_en=rd_en=1 with an incrementing din. Count stays 8 and output order is preserved across pointer wrap.
- FWFT: write 0xA5 into empty FIFO. dout=0xA5 and empty=0 the next cycle without a read. A read pops it, after which dout=0 and empty=1.
- Reset mid-operation: with count=5, assert rst alongside wr_en. After the edge count=0, empty=1 and dout=0. The next read is rejected with an underflow pulse.
